// File: rtl/bakraid_snd_pkg.sv
// Shared types and constants for the Bakraid sound-side SDRAM plumbing.
package bakraid_snd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } pcm_state_e;

    localparam int unsigned PCM_N    = 3;
    localparam int unsigned PCM_AW   = 22;
    localparam logic [21:0] PCM_BASE = 22'h0;

endpackage

// File: rtl/bakraid_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo N.
module bakraid_rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] pos;

    // Scan from lowest priority to highest so the last hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = PW'((32'(ptr) + N - 1 - k) % N);
            if (req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/bakraid_pcm_arbiter.sv
// Shares one SDRAM bank read port among the YMZ PCM channels, each fronted
// by a one-word cache; misses are fetched in round-robin order.
module bakraid_pcm_arbiter
    import bakraid_snd_pkg::*;
#(
    parameter int unsigned N    = PCM_N,
    parameter int unsigned AW   = PCM_AW,
    parameter logic [21:0] BASE = PCM_BASE
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            DOWNLOADING,
    input  logic [N-1:0]    REQ_CS,
    input  logic [N*AW-1:0] REQ_ADDR,
    output logic [N-1:0]    REQ_OK,
    output logic [N*8-1:0]  REQ_DOUT,
    output logic [21:0]     BA_ADDR,
    output logic            BA_RD,
    input  logic            BA_ACK,
    input  logic            BA_RDY,
    input  logic [15:0]     DATA_READ,
    output logic            BUSY
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = AW - 1;

    pcm_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, gnt_q;
    logic [TW-1:0] ltag_q;
    logic [TW-1:0] tag_q  [N];
    logic [15:0]   word_q [N];
    logic [N-1:0]  valid_q;
    logic [N-1:0]  hit, miss;
    logic [AW-1:0] addr   [N];
    logic          pick_any;
    logic [PW-1:0] pick_idx;
    logic          start, done;

    // Per-requester tag compare gives zero-latency hits.
    for (genvar i = 0; i < int'(N); i++) begin : g_req
        assign addr[i]           = REQ_ADDR[i*AW +: AW];
        assign hit[i]            = valid_q[i] & (tag_q[i] == addr[i][AW-1:1]);
        assign miss[i]           = REQ_CS[i] & ~hit[i];
        assign REQ_OK[i]         = REQ_CS[i] & hit[i];
        assign REQ_DOUT[i*8 +: 8] = addr[i][0] ? word_q[i][15:8] : word_q[i][7:0];
    end

    bakraid_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (miss),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign BUSY = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!DOWNLOADING && pick_any) begin
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // ACK and RDY together is a complete transaction.
                if (BA_ACK) begin
                    if (BA_RDY) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (BA_RDY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            BA_RD   <= 1'b0;
            BA_ADDR <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ltag_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                tag_q[i]  <= '0;
                word_q[i] <= '0;
            end
        end else begin
            BA_RD <= (state_d == REQ);
            if (start) begin
                gnt_q   <= pick_idx;
                ltag_q  <= addr[pick_idx][AW-1:1];
                BA_ADDR <= BASE + 22'(addr[pick_idx][AW-1:1]);
            end
            if (done) begin
                word_q[gnt_q] <= DATA_READ;
                tag_q[gnt_q]  <= ltag_q;
                ptr_q         <= (gnt_q == PW'(N - 1)) ? '0 : gnt_q + 1'b1;
            end
            // A fill landing during a ROM load keeps its valid bit cleared.
            for (int i = 0; i < int'(N); i++) begin
                if (DOWNLOADING)                       valid_q[i] <= 1'b0;
                else if (done && (gnt_q == PW'(i)))    valid_q[i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bakraid_pcm_arbiter.sv
// Directed bench for bakraid_pcm_arbiter with a simple bank responder.
module tb_bakraid_pcm_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 22;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic            DOWNLOADING = 1'b0;
    logic [N-1:0]    REQ_CS = '0;
    logic [N*AW-1:0] REQ_ADDR = '0;
    logic [N-1:0]    REQ_OK;
    logic [N*8-1:0]  REQ_DOUT;
    logic [21:0]     BA_ADDR;
    logic            BA_RD;
    logic            BA_ACK = 1'b0;
    logic            BA_RDY = 1'b0;
    logic [15:0]     DATA_READ = '0;
    logic            BUSY;

    int checks = 0;
    int failures = 0;

    bakraid_pcm_arbiter #(.N(N), .AW(AW), .BASE(22'h0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DOWNLOADING (DOWNLOADING),
        .REQ_CS      (REQ_CS),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_OK      (REQ_OK),
        .REQ_DOUT    (REQ_DOUT),
        .BA_ADDR     (BA_ADDR),
        .BA_RD       (BA_RD),
        .BA_ACK      (BA_ACK),
        .BA_RDY      (BA_RDY),
        .DATA_READ   (DATA_READ),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [21:0] a);
        REQ_ADDR[i*AW +: AW] = a;
    endtask

    function automatic logic [7:0] dout(input int i);
        return REQ_DOUT[i*8 +: 8];
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        DOWNLOADING = 1'b0;
        REQ_CS = '0;
        REQ_ADDR = '0;
        BA_ACK = 1'b0;
        BA_RDY = 1'b0;
        DATA_READ = '0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    // Bounded wait for a bank read strobe; caller judges the outcome.
    task automatic wait_rd(output bit got, output logic [21:0] a);
        got = 1'b0;
        a = '0;
        for (int c = 0; c < 20; c++) begin
            if (BA_RD === 1'b1) begin
                got = 1'b1;
                a = BA_ADDR;
                return;
            end
            tick();
        end
    endtask

    task automatic ack_rdy(input logic [15:0] d);
        BA_ACK = 1'b1;
        tick();
        BA_ACK = 1'b0;
        BA_RDY = 1'b1;
        DATA_READ = d;
        tick();
        BA_RDY = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        checks++;
        if (BA_RD !== 1'b0 || BUSY !== 1'b0 || BA_ADDR !== 22'h0) begin
            failures++;
            $display("FAIL reset_bank rd=%b busy=%b addr=%h required rd=0 busy=0 addr=000000", BA_RD, BUSY, BA_ADDR);
        end
        checks++;
        if (REQ_OK !== 3'b000 || REQ_DOUT !== 24'h0) begin
            failures++;
            $display("FAIL reset_req ok=%b dout=%h required ok=000 dout=000000", REQ_OK, REQ_DOUT);
        end
    endtask

    task automatic test_basic_hit();
        bit got;
        logic [21:0] a;
        do_reset();
        set_addr(0, 22'h000104);
        REQ_CS = 3'b001;
        wait_rd(got, a);
        checks++;
        if (got !== 1'b1 || a !== 22'h000082) begin
            failures++;
            $display("FAIL basic_grant got=%b addr=%h required got=1 addr=000082", got, a);
        end
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy busy=%b required 1", BUSY);
        end
        ack_rdy(16'hBEEF);
        checks++;
        if (REQ_OK !== 3'b001 || dout(0) !== 8'hEF) begin
            failures++;
            $display("FAIL basic_fill ok=%b dout0=%h required ok=001 dout0=ef", REQ_OK, dout(0));
        end
        set_addr(0, 22'h000105);
        #1;
        checks++;
        if (REQ_OK !== 3'b001 || dout(0) !== 8'hBE) begin
            failures++;
            $display("FAIL basic_hi_byte ok=%b dout0=%h required ok=001 dout0=be", REQ_OK, dout(0));
        end
        tick();
        tick();
        checks++;
        if (BA_RD !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_refetch rd=%b busy=%b required rd=0 busy=0", BA_RD, BUSY);
        end
        REQ_CS = '0;
    endtask

    task automatic test_round_robin();
        bit got;
        logic [21:0] a;
        logic [21:0] exp_a [3];
        exp_a[0] = 22'h000100;
        exp_a[1] = 22'h000201;
        exp_a[2] = 22'h000403;
        do_reset();
        set_addr(0, 22'h000200);
        set_addr(1, 22'h000402);
        set_addr(2, 22'h000806);
        REQ_CS = 3'b111;
        for (int k = 0; k < 3; k++) begin
            wait_rd(got, a);
            checks++;
            if (got !== 1'b1 || a !== exp_a[k]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b addr=%h required got=1 addr=%h", k, got, a, exp_a[k]);
            end
            ack_rdy(16'h1111 * 16'(k + 1));
        end
        checks++;
        if (REQ_OK !== 3'b111 || REQ_DOUT !== 24'h332211) begin
            failures++;
            $display("FAIL rr_all_ok ok=%b dout=%h required ok=111 dout=332211", REQ_OK, REQ_DOUT);
        end
        // Re-miss 0 and 2 together; pointer sits at 0 after serving 2.
        set_addr(0, 22'h000300);
        set_addr(2, 22'h000900);
        exp_a[0] = 22'h000180;
        exp_a[1] = 22'h000480;
        for (int k = 0; k < 2; k++) begin
            wait_rd(got, a);
            checks++;
            if (got !== 1'b1 || a !== exp_a[k]) begin
                failures++;
                $display("FAIL rr_remiss%0d got=%b addr=%h required got=1 addr=%h", k, got, a, exp_a[k]);
            end
            ack_rdy(16'h4400 + 16'(k));
        end
        checks++;
        if (REQ_OK !== 3'b111 || REQ_DOUT !== 24'h012200) begin
            failures++;
            $display("FAIL rr_remiss_ok ok=%b dout=%h required ok=111 dout=012200", REQ_OK, REQ_DOUT);
        end
        REQ_CS = '0;
    endtask

    task automatic test_addr_change();
        bit got;
        logic [21:0] a;
        do_reset();
        set_addr(1, 22'h000010);
        REQ_CS = 3'b010;
        wait_rd(got, a);
        checks++;
        if (got !== 1'b1 || a !== 22'h000008) begin
            failures++;
            $display("FAIL chg_grant got=%b addr=%h required got=1 addr=000008", got, a);
        end
        BA_ACK = 1'b1;
        tick();
        BA_ACK = 1'b0;
        set_addr(1, 22'h000200);
        BA_RDY = 1'b1;
        DATA_READ = 16'h5A3C;
        tick();
        BA_RDY = 1'b0;
        checks++;
        if (REQ_OK[1] !== 1'b0) begin
            failures++;
            $display("FAIL chg_ok_new ok1=%b required 0", REQ_OK[1]);
        end
        // Old odd address should hit the tag that was actually filled.
        set_addr(1, 22'h000011);
        #1;
        checks++;
        if (REQ_OK[1] !== 1'b1 || dout(1) !== 8'h5A) begin
            failures++;
            $display("FAIL chg_old_tag ok1=%b dout1=%h required ok1=1 dout1=5a", REQ_OK[1], dout(1));
        end
        set_addr(1, 22'h000200);
        wait_rd(got, a);
        checks++;
        if (got !== 1'b1 || a !== 22'h000100) begin
            failures++;
            $display("FAIL chg_refetch got=%b addr=%h required got=1 addr=000100", got, a);
        end
        ack_rdy(16'h7788);
        checks++;
        if (REQ_OK[1] !== 1'b1 || dout(1) !== 8'h88) begin
            failures++;
            $display("FAIL chg_refill ok1=%b dout1=%h required ok1=1 dout1=88", REQ_OK[1], dout(1));
        end
        REQ_CS = '0;
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [21:0] a;
        do_reset();
        set_addr(2, 22'h000044);
        REQ_CS = 3'b100;
        wait_rd(got, a);
        checks++;
        if (got !== 1'b1 || a !== 22'h000022) begin
            failures++;
            $display("FAIL b2b_grant got=%b addr=%h required got=1 addr=000022", got, a);
        end
        BA_ACK = 1'b1;
        BA_RDY = 1'b1;
        DATA_READ = 16'hCAFE;
        tick();
        BA_ACK = 1'b0;
        BA_RDY = 1'b0;
        checks++;
        if (BA_RD !== 1'b0 || BUSY !== 1'b0 || REQ_OK !== 3'b100 || dout(2) !== 8'hFE) begin
            failures++;
            $display("FAIL b2b_complete rd=%b busy=%b ok=%b dout2=%h required rd=0 busy=0 ok=100 dout2=fe",
                     BA_RD, BUSY, REQ_OK, dout(2));
        end
        tick();
        checks++;
        if (BA_RD !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL b2b_single rd=%b busy=%b required rd=0 busy=0", BA_RD, BUSY);
        end
        REQ_CS = '0;
    endtask

    task automatic test_download();
        bit got;
        bit rd_seen;
        logic [21:0] a;
        logic [21:0] exp_a [3];
        exp_a[0] = 22'h000010;
        exp_a[1] = 22'h000020;
        exp_a[2] = 22'h000030;
        do_reset();
        for (int i = 0; i < 3; i++) set_addr(i, exp_a[i] << 1);
        REQ_CS = 3'b111;
        for (int k = 0; k < 3; k++) begin
            wait_rd(got, a);
            ack_rdy(16'h0101 * 16'(k + 1));
        end
        checks++;
        if (REQ_OK !== 3'b111) begin
            failures++;
            $display("FAIL dl_warm ok=%b required 111", REQ_OK);
        end
        DOWNLOADING = 1'b1;
        rd_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (BA_RD !== 1'b0) rd_seen = 1'b1;
            checks++;
            if (REQ_OK !== 3'b000) begin
                failures++;
                $display("FAIL dl_ok_cycle%0d ok=%b required 000", c, REQ_OK);
            end
        end
        checks++;
        if (rd_seen !== 1'b0) begin
            failures++;
            $display("FAIL dl_no_grant rd_seen=%b required 0", rd_seen);
        end
        DOWNLOADING = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_rd(got, a);
            checks++;
            if (got !== 1'b1 || a !== exp_a[k]) begin
                failures++;
                $display("FAIL dl_refetch%0d got=%b addr=%h required got=1 addr=%h", k, got, a, exp_a[k]);
            end
            ack_rdy(16'h0A0A * 16'(k + 1));
        end
        checks++;
        if (REQ_OK !== 3'b111 || REQ_DOUT !== 24'h1E140A) begin
            failures++;
            $display("FAIL dl_refill ok=%b dout=%h required ok=111 dout=1e140a", REQ_OK, REQ_DOUT);
        end
        REQ_CS = '0;
    endtask

    task automatic test_reset_in_wait();
        bit got;
        logic [21:0] a;
        do_reset();
        set_addr(0, 22'h000020);
        REQ_CS = 3'b001;
        wait_rd(got, a);
        checks++;
        if (got !== 1'b1 || a !== 22'h000010) begin
            failures++;
            $display("FAIL rst_grant got=%b addr=%h required got=1 addr=000010", got, a);
        end
        BA_ACK = 1'b1;
        tick();
        BA_ACK = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_wait busy=%b required 1", BUSY);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (BA_RD !== 1'b0 || BUSY !== 1'b0 || REQ_OK !== 3'b000) begin
            failures++;
            $display("FAIL rst_async rd=%b busy=%b ok=%b required rd=0 busy=0 ok=000", BA_RD, BUSY, REQ_OK);
        end
        REQ_CS = '0;
        tick();
        RESET = 1'b0;
        tick();
        BA_RDY = 1'b1;
        DATA_READ = 16'h1234;
        tick();
        BA_RDY = 1'b0;
        REQ_CS = 3'b001;
        #1;
        checks++;
        if (REQ_OK !== 3'b000 || dout(0) !== 8'h00) begin
            failures++;
            $display("FAIL rst_late_rdy ok=%b dout0=%h required ok=000 dout0=00", REQ_OK, dout(0));
        end
        REQ_CS = '0;
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_round_robin();
        test_addr_change();
        test_back_to_back();
        test_download();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
